// File: rtl/boothr4_param.sv
`default_nettype none
// ============================================================================
// boothr4_param : radix-4 Booth sequential multiplier, W-bit serial bus I/O
// Rev 1.0
// ============================================================================
module boothr4_param #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         beginsig,
  input  logic         locksig,
  input  logic         signed_mode,
  input  logic [W-1:0] inbus,
  output logic [W-1:0] outbus,
  output logic         outvalid,
  output logic         endsig,
  output logic         busy
);

  localparam int K  = W / 2 + 1;
  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] C_LAST = CW'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_Q = 3'd1,
    S_RUN    = 3'd2,
    S_OUT_HI = 3'd3,
    S_OUT_LO = 3'd4
  } state_t;

  state_t          r_state;
  logic [W+1:0]    r_m;
  logic            r_sm;
  logic [W+3:0]    r_a;
  logic [W+1:0]    r_q;
  logic            r_q1;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_outbus;
  logic            r_outvalid;
  logic            r_endsig;
  logic            r_busy;

  logic [W+3:0]    w_m4;
  logic [W+3:0]    w_add;
  logic [W+3:0]    w_sum;
  logic [W+3:0]    w_a_nx;
  logic [W+1:0]    w_q_nx;

  function automatic logic [W+1:0] ext(input logic [W-1:0] v, input logic s);
    ext = {{2{s & v[W-1]}}, v};
  endfunction

  assign w_m4 = {{2{r_m[W+1]}}, r_m};

  always_comb begin
    w_add = '0;
    case ({r_q[1:0], r_q1})
      3'b001, 3'b010: w_add = w_m4;
      3'b011:         w_add = {w_m4[W+2:0], 1'b0};
      3'b100:         w_add = -{w_m4[W+2:0], 1'b0};
      3'b101, 3'b110: w_add = -w_m4;
      default:        w_add = '0;
    endcase
  end

  // Arithmetic shift of {A,Q,q-1} by two after the add; the new high product
  // word {A[W-3:0],Q[W+1:W]} is therefore exactly w_sum[W-1:0].
  assign w_sum  = r_a + w_add;
  assign w_a_nx = {{2{w_sum[W+3]}}, w_sum[W+3:2]};
  assign w_q_nx = {w_sum[1:0], r_q[W+1:2]};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= S_IDLE;
      r_m        <= '0;
      r_sm       <= 1'b0;
      r_a        <= '0;
      r_q        <= '0;
      r_q1       <= 1'b0;
      r_cnt      <= '0;
      r_outbus   <= '0;
      r_outvalid <= 1'b0;
      r_endsig   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (beginsig && !locksig) begin
          r_m     <= ext(inbus, signed_mode);
          r_sm    <= signed_mode;
          r_busy  <= 1'b1;
          r_state <= S_LOAD_Q;
        end
        S_LOAD_Q: if (!locksig) begin
          r_q     <= ext(inbus, r_sm);
          r_a     <= '0;
          r_q1    <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: if (!locksig) begin
          r_a   <= w_a_nx;
          r_q   <= w_q_nx;
          r_q1  <= r_q[1];
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            r_outbus   <= w_sum[W-1:0];
            r_outvalid <= 1'b1;
            r_state    <= S_OUT_HI;
          end
        end
        S_OUT_HI: if (!locksig) begin
          r_outbus <= r_q[W-1:0];
          r_endsig <= 1'b1;
          r_state  <= S_OUT_LO;
        end
        S_OUT_LO: if (!locksig) begin
          r_outbus   <= '0;
          r_outvalid <= 1'b0;
          r_endsig   <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign outbus   = r_outbus;
  assign outvalid = r_outvalid;
  assign endsig   = r_endsig;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_boothr4_param.sv
`default_nettype none
// Directed bench for boothr4_param at W=8 and W=16.
module tb_boothr4_param;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        b8, l8, s8;
  logic [7:0]  in8, out8;
  logic        ov8, es8, bz8;
  logic        b16, l16, s16;
  logic [15:0] in16, out16;
  logic        ov16, es16, bz16;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  boothr4_param #(.W(8)) u_dut8 (
    .clk(clk), .rst_b(rst_b), .beginsig(b8), .locksig(l8), .signed_mode(s8),
    .inbus(in8), .outbus(out8), .outvalid(ov8), .endsig(es8), .busy(bz8)
  );

  boothr4_param #(.W(16)) u_dut16 (
    .clk(clk), .rst_b(rst_b), .beginsig(b16), .locksig(l16), .signed_mode(s16),
    .inbus(in16), .outbus(out16), .outvalid(ov16), .endsig(es16), .busy(bz16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the start of an IDLE cycle (cycle 0); returns in the first
  // IDLE cycle after the product, so calls can run back to back.
  task automatic mul8(input logic [7:0] m, input logic [7:0] q, input logic sgn,
                      input logic [15:0] p, input string tag);
    b8 = 1'b1; in8 = m; s8 = sgn;
    tick();                                   // cycle 1
    chk({tag, " busy c1"}, {31'd0, bz8}, 32'd1);
    b8 = 1'b0; in8 = q; s8 = ~sgn;
    tick();                                   // cycle 2
    in8 = 8'h5A;
    for (int i = 0; i < 4; i++) tick();       // cycle 6
    chk({tag, " idle bus c6"}, {23'd0, ov8, out8}, 32'd0);
    tick();                                   // cycle 7
    chk({tag, " hi"}, {22'd0, ov8, es8, out8}, {22'd0, 1'b1, 1'b0, p[15:8]});
    tick();                                   // cycle 8
    chk({tag, " lo"}, {22'd0, ov8, es8, out8}, {22'd0, 1'b1, 1'b1, p[7:0]});
    tick();                                   // cycle 9
    chk({tag, " done"}, {21'd0, bz8, ov8, es8, out8}, 32'd0);
  endtask

  initial begin
    rst_b = 1'b0;
    b8 = 1'b0; l8 = 1'b0; s8 = 1'b0; in8 = '0;
    b16 = 1'b0; l16 = 1'b0; s16 = 1'b0; in16 = '0;
    tick();
    tick();
    chk("reset w8", {21'd0, bz8, ov8, es8, out8}, 32'd0);
    chk("reset w16", {13'd0, bz16, ov16, es16, out16}, 32'd0);
    rst_b = 1'b1;

    mul8(8'hF9, 8'h0D, 1'b1, 16'hFFA5, "s F9xD");
    mul8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u FFxFF");
    mul8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s FFxFF");
    mul8(8'h80, 8'h80, 1'b1, 16'h4000, "s 80x80");
    mul8(8'h80, 8'h80, 1'b0, 16'h4000, "u 80x80");
    mul8(8'h00, 8'hAB, 1'b0, 16'h0000, "u 00xAB");

    // Locks: 3 cycles in RUN, 2 in OUT_HI; stray beginsig while busy.
    b8 = 1'b1; in8 = 8'hC8; s8 = 1'b0;        // cycle 0
    tick(); b8 = 1'b0; in8 = 8'h37;           // cycle 1
    tick();                                   // cycle 2
    tick(); b8 = 1'b1; in8 = 8'hFF; s8 = 1'b1; // cycle 3
    tick(); b8 = 1'b0; l8 = 1'b1;             // cycle 4
    tick();                                   // cycle 5
    chk("lock busy", {23'd0, bz8, ov8, out8[6:0]}, {23'd0, 1'b1, 1'b0, 7'd0});
    tick();                                   // cycle 6
    tick(); l8 = 1'b0;                        // cycle 7
    tick(); tick();                           // cycle 9
    chk("lock not early", {31'd0, ov8}, 32'd0);
    tick();                                   // cycle 10
    chk("lock hi", {22'd0, ov8, es8, out8}, {22'd0, 1'b1, 1'b0, 8'h2A});
    l8 = 1'b1;
    tick();                                   // cycle 11
    chk("lock hi held1", {22'd0, ov8, es8, out8}, {22'd0, 1'b1, 1'b0, 8'h2A});
    tick();                                   // cycle 12
    chk("lock hi held2", {22'd0, ov8, es8, out8}, {22'd0, 1'b1, 1'b0, 8'h2A});
    l8 = 1'b0;
    tick();                                   // cycle 13
    chk("lock lo", {22'd0, ov8, es8, out8}, {22'd0, 1'b1, 1'b1, 8'hF8});
    tick();                                   // cycle 14
    chk("lock done", {21'd0, bz8, ov8, es8, out8}, 32'd0);
    tick();
    chk("no queued start", {31'd0, bz8}, 32'd0);

    // Asynchronous reset in the middle of RUN.
    b8 = 1'b1; in8 = 8'hF9; s8 = 1'b1;        // cycle 0
    tick(); b8 = 1'b0; in8 = 8'h0D;           // cycle 1
    tick(); tick(); tick();                   // cycle 4
    chk("pre-reset busy", {31'd0, bz8}, 32'd1);
    #2 rst_b = 1'b0;
    #1 chk("async reset", {21'd0, bz8, ov8, es8, out8}, 32'd0);
    tick(); tick();
    chk("held reset", {21'd0, bz8, ov8, es8, out8}, 32'd0);
    rst_b = 1'b1;
    mul8(8'h05, 8'h03, 1'b0, 16'h000F, "u 05x03 after reset");

    // W=16 signed 0x8000 x 0x7FFF: K=9, high word in cycle 11.
    b16 = 1'b1; in16 = 16'h8000; s16 = 1'b1;  // cycle 0
    tick(); b16 = 1'b0; in16 = 16'h7FFF; s16 = 1'b0;
    tick(); in16 = 16'h1234;                  // cycle 2
    for (int i = 0; i < 8; i++) tick();       // cycle 10
    chk("w16 not early", {15'd0, ov16, out16}, 32'd0);
    tick();                                   // cycle 11
    chk("w16 hi", {14'd0, ov16, es16, out16}, {14'd0, 1'b1, 1'b0, 16'hC000});
    tick();                                   // cycle 12
    chk("w16 lo", {14'd0, ov16, es16, out16}, {14'd0, 1'b1, 1'b1, 16'h8000});
    tick();
    chk("w16 done", {13'd0, bz16, ov16, es16, out16}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boothr4_param.md
# boothr4_param

Parametrised radix-4 Booth sequential multiplier with a W-bit serial load/unload bus. Operands and the 2W-bit product cross the bus one W-bit word per cycle under a beginsig/locksig/endsig handshake. The block adds signed/unsigned mode selection, a stall input honoured in every active state, explicit busy/outvalid status and an asynchronous active-low reset. It sits beside the fixed 8-bit Booth unit as its generalised replacement in the arithmetic datapath.

## Interface
- W, default 8: operand width; must be even and ≥4; product is 2W bits.
- clk  input  1  single clock; all state on rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- beginsig  input  1  start request, sampled in IDLE; the same cycle carries the multiplicand on inbus.
- locksig  input  1  stall; freezes FSM, counter and datapath while high.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with beginsig.
- inbus  input  W  operand input.
- outbus  output  W  product output: high word, then low word.
- outvalid  output  1  high while outbus carries a product word.
- endsig  output  1  one-cycle pulse with the low product word.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD_Q, RUN, OUT_HI, OUT_LO.
- IDLE: if beginsig=1 and locksig=0, capture inbus as multiplicand M and latch signed_mode; go to LOAD_Q. Otherwise stay.
- LOAD_Q: capture inbus as multiplier Q; clear accumulator A and q_-1; clear counter; go to RUN.
- Operand extension: M and Q are extended to W+2 bits, sign-extended if signed_mode else zero-extended. Both modes use the same iteration count K = W/2+1.
- RUN: one radix-4 step per cycle; decode {Q[1],Q[0],q_-1}:
  - 000/111 → +0
  - 001/010 → +M
  - 011 → +2M
  - 100 → −2M
  - 101/110 → −M
- A is W+4 bits, so the sum never overflows. After the add, arithmetic-shift {A,Q,q_-1} right by 2.
- After K steps go to OUT_HI. Product P is bits [2W−1:0] of {A,Q}, which is exact in both modes.
- OUT_HI: outbus = P[2W−1:W], outvalid=1; next OUT_LO.
- OUT_LO: outbus = P[W−1:0], outvalid=1, endsig=1; next IDLE.
- outbus = 0 whenever outvalid=0.
- locksig=1 in any non-IDLE state: hold state, counter, registers and outputs unchanged.
  - In OUT_HI/OUT_LO this repeats the word, with endsig held high for the duration.
  - In LOAD_Q the operand is captured on the first unlocked edge.
- beginsig is ignored in IDLE while locksig=1, and in every non-IDLE state. A pending start never queues.
- signed_mode and inbus changes outside their capture cycles have no effect.

## Timing
- Reset (rst_b=0, asynchronous): state=IDLE, outbus=0, outvalid=0, endsig=0, busy=0. All operand registers and the counter are cleared.
- Reset mid-operation aborts immediately; no partial product appears. The first edge after release may accept beginsig.
- Numbering the beginsig-sampled cycle as cycle 0, with no locks:
  - Multiplier is captured at the end of cycle 1.
  - RUN occupies cycles 2..K+1.
  - OUT_HI is cycle K+2; OUT_LO/endsig is cycle K+3.
  - busy is high from cycle 1 to cycle K+3.
- Example: W=8 → K=5, high word in cycle 7, endsig in cycle 8.
- Each locked cycle delays all later events by exactly one cycle.
- Back-to-back: beginsig may be asserted in the cycle after OUT_LO (first IDLE cycle). Minimum period is K+4 cycles.
- All outputs are decoded from registered state and product only; there is no combinational path from any input.

## Test plan
- W=8, signed, M=0xF9 (−7), Q=0x0D → outbus 0xFF in cycle 7, 0xA5 with endsig in cycle 8 (−91).
- W=8, M=Q=0xFF:
  - unsigned → 0xFE then 0x01.
  - signed → 0x00 then 0x01.
- W=8, signed, 0x80×0x80 → 0x40, 0x00; unsigned 0x80×0x80 → 0x40, 0x00; unsigned 0x00×0xAB → 0x00, 0x00.
- W=8, locksig high 3 cycles mid-RUN and 2 cycles in OUT_HI → same product; endsig appears in cycle 13 and lasts 1 cycle. beginsig pulsed while busy → ignored.
- rst_b low during RUN cycle 4 → all outputs 0 asynchronously. Restart after release with 0x05×0x03 unsigned → 0x00, 0x0F.
- W=16, signed, 0x8000×0x7FFF → 0xC000 in cycle 11, 0x8000 with endsig in cycle 12.
